// File: rtl/btb_write_scheduler_pkg.sv
// Shared types and helpers for the BTB write-port scheduler.
// Queue entries are sized for the default geometry; smaller arrays zero-extend into them.
package btb_write_scheduler_pkg;

  localparam int BTB_IDX_W       = 10;
  localparam int BTB_DATA_W      = 40;
  localparam int BTB_QUEUE_DEPTH = 8;
  localparam int BTB_QPTR_W      = $clog2(BTB_QUEUE_DEPTH);

  typedef struct packed {
    logic [BTB_IDX_W-1:0]  index;
    logic [BTB_DATA_W-1:0] data;
  } btb_qentry_t;

  typedef logic [0:0] btb_state_t;
  localparam btb_state_t ST_INIT = 1'b0;
  localparam btb_state_t ST_RUN  = 1'b1;

  function automatic logic [BTB_IDX_W-1:0] BTB_BankOf(input logic [BTB_IDX_W-1:0] idx,
                                                      input int unsigned          bank_num);
    return idx & BTB_IDX_W'(bank_num - 32'd1);
  endfunction

  function automatic logic IsBankConflict(input logic [BTB_IDX_W-1:0] a,
                                          input logic [BTB_IDX_W-1:0] b,
                                          input int unsigned          bank_num);
    return BTB_BankOf(a, bank_num) == BTB_BankOf(b, bank_num);
  endfunction

endpackage

// File: rtl/btb_write_scheduler_defer_queue.sv
// Deferred-write FIFO: single push, single pop, occupancy count and synchronous clear.
// A push into a full queue is accepted only when the head leaves in the same cycle.
module btb_defer_queue
  import btb_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = BTB_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  btb_qentry_t  push_data_i,
  input  logic         pop_i,
  output btb_qentry_t  head_o,
  output logic [PTR_W:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  btb_qentry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_push_s = push_i && !clr_i && (!full_o || pop_i);
    do_pop_s  = pop_i && !clr_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop_s);
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/btb_write_scheduler.sv
// BTB write-port scheduler: init sweep, per-cycle bank-conflict grant, deferral FIFO replay
// into idle ports, and drop accounting. All RAM-facing outputs are registered.
module btb_write_scheduler
  import btb_write_scheduler_pkg::*;
#(
  parameter  int WRITE_NUM   = 2,
  parameter  int ENTRY_NUM   = 1024,
  parameter  int BANK_NUM    = 2,
  parameter  int QUEUE_DEPTH = 8,
  parameter  int DATA_W      = 40,
  localparam int IDX_W       = $clog2(ENTRY_NUM),
  localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1,
  localparam int DROP_W      = $clog2(WRITE_NUM + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [WRITE_NUM-1:0]             reqValid,
  input  logic [WRITE_NUM-1:0][IDX_W-1:0]  reqAddr,
  input  logic [WRITE_NUM-1:0][DATA_W-1:0] reqData,
  output logic [WRITE_NUM-1:0]             we,
  output logic [WRITE_NUM-1:0][IDX_W-1:0]  wa,
  output logic [WRITE_NUM-1:0][DATA_W-1:0] wv,
  output logic                             initBusy,
  output logic [CNT_W-1:0]                 queueCount,
  output logic                             dropPulse,
  output logic [15:0]                      dropCount
);

  btb_state_t                       state_q, state_d;
  logic [IDX_W-1:0]                 init_idx_q, init_idx_d;
  logic [WRITE_NUM-1:0]             we_q, we_d;
  logic [WRITE_NUM-1:0][IDX_W-1:0]  wa_q, wa_d;
  logic [WRITE_NUM-1:0][DATA_W-1:0] wv_q, wv_d;
  logic                             drop_pulse_q, drop_pulse_d;
  logic [15:0]                      drop_count_q, drop_count_d;
  logic [16:0]                      drop_sum_s;
  logic [DROP_W-1:0]                drop_n_s;
  logic [WRITE_NUM-1:0]             grant_s;
  logic                             blocked_s, head_ok_s, placed_s, deferred_s;
  logic                             q_push_s, q_pop_s, q_full_s, q_empty_s;
  btb_qentry_t                      q_push_data_s, q_head_s;

  btb_defer_queue #(.DEPTH(QUEUE_DEPTH)) u_defer_queue (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_i       (flush),
    .push_i      (q_push_s),
    .push_data_i (q_push_data_s),
    .pop_i       (q_pop_s),
    .head_o      (q_head_s),
    .count_o     (queueCount),
    .full_o      (q_full_s),
    .empty_o     (q_empty_s)
  );

  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    we_d          = '0;
    wa_d          = '0;
    wv_d          = '0;
    grant_s       = '0;
    blocked_s     = 1'b0;
    head_ok_s     = 1'b0;
    placed_s      = 1'b0;
    deferred_s    = 1'b0;
    q_push_s      = 1'b0;
    q_pop_s       = 1'b0;
    q_push_data_s = '0;
    drop_n_s      = '0;
    if (flush) begin
      state_d    = ST_INIT;
      init_idx_d = '0;
    end else if (state_q == ST_INIT) begin
      we_d[0]    = 1'b1;
      wa_d[0]    = init_idx_q;
      init_idx_d = init_idx_q + IDX_W'(1);
      if (init_idx_q == IDX_W'(ENTRY_NUM - 1)) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_INIT;
      end
    end else begin
      // Grant in port order; a port loses only to a lower-index grant in the same bank.
      for (int i = 0; i < WRITE_NUM; i++) begin
        blocked_s = 1'b0;
        for (int j = 0; j < WRITE_NUM; j++) begin
          blocked_s = blocked_s | ((j < i) && grant_s[j] &&
                      IsBankConflict(BTB_IDX_W'(reqAddr[i]), BTB_IDX_W'(reqAddr[j]), BANK_NUM));
        end
        if (reqValid[i] && !blocked_s) begin
          grant_s[i] = 1'b1;
          we_d[i]    = 1'b1;
          wa_d[i]    = reqAddr[i];
          wv_d[i]    = reqData[i];
        end else begin
          grant_s[i] = 1'b0;
        end
      end
      head_ok_s = !q_empty_s;
      for (int i = 0; i < WRITE_NUM; i++) begin
        head_ok_s = head_ok_s & ~(grant_s[i] &
                    IsBankConflict(q_head_s.index, BTB_IDX_W'(reqAddr[i]), BANK_NUM));
      end
      for (int i = 0; i < WRITE_NUM; i++) begin
        if (head_ok_s && !placed_s && !grant_s[i]) begin
          placed_s = 1'b1;
          q_pop_s  = 1'b1;
          we_d[i]  = 1'b1;
          wa_d[i]  = q_head_s.index[IDX_W-1:0];
          wv_d[i]  = q_head_s.data[DATA_W-1:0];
        end else begin
          placed_s = placed_s;
        end
      end
      // Only the first loser may be deferred; the queue accepts it when full only if the head leaves.
      for (int i = 0; i < WRITE_NUM; i++) begin
        if (reqValid[i] && !grant_s[i]) begin
          if (!deferred_s && (!q_full_s || q_pop_s)) begin
            q_push_s            = 1'b1;
            q_push_data_s.index = BTB_IDX_W'(reqAddr[i]);
            q_push_data_s.data  = BTB_DATA_W'(reqData[i]);
          end else begin
            drop_n_s = drop_n_s + DROP_W'(1);
          end
          deferred_s = 1'b1;
        end else begin
          deferred_s = deferred_s;
        end
      end
    end
  end

  // Saturating drop accounting.
  always_comb begin
    drop_sum_s   = {1'b0, drop_count_q} + 17'(drop_n_s);
    drop_pulse_d = (drop_n_s != '0);
    if (drop_sum_s[16]) begin
      drop_count_d = 16'hFFFF;
    end else begin
      drop_count_d = drop_sum_s[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      we_q         <= '0;
      wa_q         <= '0;
      wv_q         <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      wv_q         <= wv_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign we        = we_q;
  assign wa        = wa_q;
  assign wv        = wv_q;
  assign initBusy  = (state_q == ST_INIT);
  assign dropPulse = drop_pulse_q;
  assign dropCount = drop_count_q;

endmodule

// File: tb/tb_btb_write_scheduler.sv
// Self-checking bench for btb_write_scheduler (16 entries, 2 ports, 2 banks, depth 8):
// directed vector table plus randomized traffic against a queue-based reference model.
module tb_btb_write_scheduler;

  localparam int WN = 2;
  localparam int EN = 16;
  localparam int BN = 2;
  localparam int QD = 8;
  localparam int DW = 40;
  localparam int IW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [WN-1:0]          reqValid;
  logic [WN-1:0][IW-1:0]  reqAddr;
  logic [WN-1:0][DW-1:0]  reqData;
  logic [WN-1:0]          we;
  logic [WN-1:0][IW-1:0]  wa;
  logic [WN-1:0][DW-1:0]  wv;
  logic                   initBusy;
  logic [3:0]             queueCount;
  logic                   dropPulse;
  logic [15:0]            dropCount;

  btb_write_scheduler #(
    .WRITE_NUM(WN), .ENTRY_NUM(EN), .BANK_NUM(BN), .QUEUE_DEPTH(QD), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData),
    .we(we), .wa(wa), .wv(wv),
    .initBusy(initBusy), .queueCount(queueCount),
    .dropPulse(dropPulse), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending writes as a plain queue, sweep as a counter.
  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  bit            m_init;
  int            m_iidx;
  int            m_dc;
  bit            e_dp;
  logic [WN-1:0] e_we;
  logic [IW-1:0] e_wa [WN];
  logic [DW-1:0] e_wv [WN];

  function automatic int bank(input logic [IW-1:0] a);
    return int'(a) % BN;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_init = 1'b1;
    m_iidx = 0;
    m_dc   = 0;
  endtask

  task automatic model_step(input bit fl, input logic [WN-1:0] v,
                            input logic [IW-1:0] a0, input logic [IW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [IW-1:0] a [WN];
    logic [DW-1:0] d [WN];
    bit            g [WN];
    bit            popped, pushed, first, ok;
    int            nd;
    ent_t          pe;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    e_we = '0; e_dp = 1'b0;
    for (int p = 0; p < WN; p++) begin e_wa[p] = '0; e_wv[p] = '0; g[p] = 1'b0; end
    if (fl) begin
      mq.delete();
      m_init = 1'b1;
      m_iidx = 0;
    end else if (m_init) begin
      e_we[0] = 1'b1;
      e_wa[0] = IW'(m_iidx);
      m_iidx++;
      if (m_iidx == EN) m_init = 1'b0;
    end else begin
      for (int p = 0; p < WN; p++) begin
        g[p] = v[p];
        for (int q = 0; q < p; q++)
          if (g[q] && bank(a[q]) == bank(a[p])) g[p] = 1'b0;
        if (g[p]) begin e_we[p] = 1'b1; e_wa[p] = a[p]; e_wv[p] = d[p]; end
      end
      popped = 1'b0;
      if (mq.size() > 0) begin
        ok = 1'b1;
        for (int p = 0; p < WN; p++)
          if (g[p] && bank(a[p]) == bank(mq[0].idx)) ok = 1'b0;
        for (int p = 0; p < WN; p++)
          if (ok && !popped && !g[p]) begin
            popped = 1'b1; e_we[p] = 1'b1; e_wa[p] = mq[0].idx; e_wv[p] = mq[0].data;
          end
      end
      first = 1'b1; pushed = 1'b0; nd = 0;
      for (int p = 0; p < WN; p++)
        if (v[p] && !g[p]) begin
          if (first && (mq.size() < QD || popped)) begin
            pushed = 1'b1; pe.idx = a[p]; pe.data = d[p];
          end else nd++;
          first = 1'b0;
        end
      if (popped) void'(mq.pop_front());
      if (pushed) mq.push_back(pe);
      e_dp = (nd > 0);
      m_dc = (m_dc + nd > 65535) ? 65535 : m_dc + nd;
    end
  endtask

  task automatic check_model();
    chk("we", 64'(we), 64'(e_we));
    for (int p = 0; p < WN; p++)
      if (e_we[p]) begin
        chk($sformatf("wa%0d", p), 64'(wa[p]), 64'(e_wa[p]));
        chk($sformatf("wv%0d", p), 64'(wv[p]), 64'(e_wv[p]));
      end
    chk("initBusy", 64'(initBusy), 64'(m_init));
    chk("queueCount", 64'(queueCount), 64'(mq.size()));
    chk("dropPulse", 64'(dropPulse), 64'(e_dp));
    chk("dropCount", 64'(dropCount), 64'(m_dc));
  endtask

  // Drive at the falling edge, let one rising edge pass, compare 1 time unit later.
  task automatic apply(input bit fl, input logic [WN-1:0] v,
                       input logic [IW-1:0] a0, input logic [IW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    flush = fl; reqValid = v;
    reqAddr[0] = a0; reqAddr[1] = a1; reqData[0] = d0; reqData[1] = d1;
    model_step(fl, v, a0, a1, d0, d1);
    @(posedge clk); #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic apply_random(input bit allow_flush);
    logic [DW-1:0] d0, d1;
    d0 = DW'({$urandom(), $urandom()});
    d1 = DW'({$urandom(), $urandom()});
    apply(allow_flush && ($urandom_range(0, 59) == 0), WN'($urandom_range(0, 3)),
          IW'($urandom_range(0, EN - 1)), IW'($urandom_range(0, EN - 1)), d0, d1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_we"}, 64'(we), 64'(0));
    chk({tag, "_wa"}, 64'(wa), 64'(0));
    chk({tag, "_wv"}, 64'(wv[0] | wv[1]), 64'(0));
    chk({tag, "_initBusy"}, 64'(initBusy), 64'(1));
    chk({tag, "_queueCount"}, 64'(queueCount), 64'(0));
    chk({tag, "_dropPulse"}, 64'(dropPulse), 64'(0));
    chk({tag, "_dropCount"}, 64'(dropCount), 64'(0));
  endtask

  typedef struct {
    logic [WN-1:0] v;
    logic [IW-1:0] a0, a1;
    logic [WN-1:0] xwe;
    logic [IW-1:0] xwa0, xwa1;
    int            xqc;
    bit            xdp;
    int            xdc;
  } vec_t;

  function automatic vec_t mk(input logic [WN-1:0] v, input int a0, input int a1,
                              input logic [WN-1:0] xwe, input int xwa0, input int xwa1,
                              input int xqc, input bit xdp, input int xdc);
    vec_t r;
    r.v = v; r.a0 = IW'(a0); r.a1 = IW'(a1); r.xwe = xwe;
    r.xwa0 = IW'(xwa0); r.xwa1 = IW'(xwa1); r.xqc = xqc; r.xdp = xdp; r.xdc = xdc;
    return r;
  endfunction

  vec_t tbl [20];
  int   nwr;

  initial begin
    // Rows applied back to back straight after the first init sweep.
    tbl[0] = mk(2'b11, 4, 5, 2'b11, 4, 5, 0, 1'b0, 0);  // different banks: both granted
    tbl[1] = mk(2'b11, 4, 6, 2'b01, 4, 0, 1, 1'b0, 0);  // same bank: 6 deferred
    tbl[2] = mk(2'b00, 0, 0, 2'b01, 6, 0, 0, 1'b0, 0);  // 6 drains on port 0
    tbl[3] = mk(2'b11, 0, 2, 2'b01, 0, 0, 1, 1'b0, 0);  // 2 deferred
    tbl[4] = mk(2'b01, 8, 0, 2'b01, 8, 0, 1, 1'b0, 0);  // 8 blocks head 2
    tbl[5] = mk(2'b00, 0, 0, 2'b01, 2, 0, 0, 1'b0, 0);
    for (int k = 0; k < 9; k++)
      tbl[6 + k] = mk(2'b11, 0, (2 * k + 2) & 14, 2'b01, 0, 0, (k < 8) ? k + 1 : 8,
                      k == 8, (k == 8) ? 1 : 0);
    for (int k = 0; k < 5; k++)
      tbl[15 + k] = mk(2'b00, 0, 0, 2'b01, 2 * k + 2, 0, 7 - k, 1'b0, 1);

    rst = 1'b0; flush = 1'b0; reqValid = '0; reqAddr = '0; reqData = '0;
    model_reset();
    #2;
    chk_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Init sweep with random request traffic that must be ignored.
    for (int c = 0; c < EN; c++) begin
      chk("init_busy_during", 64'(initBusy), 64'(1));
      apply_random(1'b0);
    end
    chk("init_done", 64'(initBusy), 64'(0));
    chk("init_no_drop", 64'(dropCount), 64'(0));

    for (int i = 0; i < 20; i++) begin
      apply(1'b0, tbl[i].v, tbl[i].a0, tbl[i].a1, DW'(40'h1000 + 2 * i), DW'(40'h1001 + 2 * i));
      chk($sformatf("tbl%0d_we", i), 64'(we), 64'(tbl[i].xwe));
      if (tbl[i].xwe[0]) chk($sformatf("tbl%0d_wa0", i), 64'(wa[0]), 64'(tbl[i].xwa0));
      if (tbl[i].xwe[1]) chk($sformatf("tbl%0d_wa1", i), 64'(wa[1]), 64'(tbl[i].xwa1));
      chk($sformatf("tbl%0d_qc", i), 64'(queueCount), 64'(tbl[i].xqc));
      chk($sformatf("tbl%0d_dp", i), 64'(dropPulse), 64'(tbl[i].xdp));
      chk($sformatf("tbl%0d_dc", i), 64'(dropCount), 64'(tbl[i].xdc));
    end

    // Flush with three queued entries and a conflicting pair in the same cycle.
    apply(1'b1, 2'b11, 4'd1, 4'd3, 40'h55, 40'h66);
    chk("flush_qc", 64'(queueCount), 64'(0));
    chk("flush_initBusy", 64'(initBusy), 64'(1));
    chk("flush_we", 64'(we), 64'(0));
    chk("flush_wa0", 64'(wa[0]), 64'(0));
    chk("flush_dc", 64'(dropCount), 64'(1));
    nwr = 0;
    for (int c = 0; c < EN; c++) begin
      apply(1'b0, 2'b11, 4'd1, 4'd3, 40'h55, 40'h66);
      if (we[0]) nwr++;
    end
    chk("flush_sweep_writes", 64'(nwr), 64'(EN));
    chk("flush_sweep_done", 64'(initBusy), 64'(0));

    for (int c = 0; c < 3000; c++) apply_random(1'b1);

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b0;
    #1 chk_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 60; c++) apply_random(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_write_scheduler.md
# btb_write_scheduler

Write-port scheduler for the banked branch target buffer array. Accepts up to WRITE_NUM BTB update requests per cycle from the integer execute stage and resolves bank conflicts between them. Conflicting writes are deferred through an internal FIFO and replayed into idle, non-conflicting ports. Also owns the array's initialization sweep after reset or flush. Sits between the branch-resolution outputs and the write ports of the multi-bank BTB RAM; drives those ports through registers.

## Interface
Parameters:
- WRITE_NUM, 2, number of request inputs and RAM write ports
- ENTRY_NUM, 1024, BTB entries (power of two); IDX_W = log2(ENTRY_NUM)
- BANK_NUM, 2, RAM banks (power of two); bank = index[log2(BANK_NUM)-1:0]
- QUEUE_DEPTH, 8, deferred-write FIFO entries (power of two)
- DATA_W, 40, BTB entry width (tag, target, valid, isCondBr packed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  pulse: discard queue and restart initialization sweep
- reqValid[WRITE_NUM]  in  1  write request valid
- reqAddr[WRITE_NUM]  in  IDX_W  entry index
- reqData[WRITE_NUM]  in  DATA_W  entry value
- we[WRITE_NUM]  out  1  RAM write enable (registered)
- wa[WRITE_NUM]  out  IDX_W  RAM write index (registered)
- wv[WRITE_NUM]  out  DATA_W  RAM write value (registered)
- initBusy  out  1  initialization sweep in progress
- queueCount  out  log2(QUEUE_DEPTH)+1  FIFO occupancy
- dropPulse  out  1  one or more requests discarded this cycle (registered)
- dropCount  out  16  saturating count of discarded requests

## Operation
- FSM states: INIT, RUN. Reset enters INIT with initIdx=0.
- INIT behaviour:
  - Each cycle: next we[0]=1, wa[0]=initIdx, wv[0]=0; other ports we=0; initIdx increments.
  - At initIdx==ENTRY_NUM-1 the FSM moves to RUN.
  - reqValid is ignored in INIT. This is not counted as a drop.
- RUN, grant pass in port order 0..WRITE_NUM-1:
  - A valid request is granted on its own port unless its bank equals the bank of a lower-index granted request.
- RUN, deferral:
  - The first non-granted request is pushed to the FIFO if the FIFO is not full, or is full but popping this cycle.
  - Otherwise it is dropped.
  - Any further non-granted requests in the same cycle are dropped.
- RUN, drain:
  - If the FIFO is non-empty, its head goes to the lowest-index port with no grant, provided the head's bank differs from every granted bank.
  - Otherwise nothing pops.
  - At most one pop per cycle. A pushed entry is not eligible for drain in its push cycle.
- Duplicate addresses are not merged. A later same-index request may overtake a queued one; the BTB tolerates stale targets.
- flush:
  - Clears FIFO pointers and count, forces INIT, and sets initIdx=0.
  - Overrides any push, pop or grant in the same cycle; those requests are not counted as drops.
  - A flush during INIT restarts the sweep.
- dropCount saturates at 16'hFFFF. Each drop adds its number of dropped requests that cycle.
- Reset values: we=0, wa=0, wv=0, initBusy=1, queueCount=0, dropPulse=0, dropCount=0.

## Timing
- Request grant latency is 1: a request granted at cycle t appears on we/wa/wv in cycle t+1.
- Deferred latency is at least 2: a request pushed at t drains no earlier than t+1 and is visible at t+2.
- initBusy = (state==INIT), registered.
  - After rst release, init writes are visible in cycles 1..ENTRY_NUM.
  - initBusy is 1 in cycles 0..ENTRY_NUM-1 and falls in cycle ENTRY_NUM. The last init write is still visible in that cycle.
- queueCount updates at the edge following push/pop; a simultaneous push and pop leaves it unchanged.
- FIFO pointers wrap modulo QUEUE_DEPTH. Full = count==QUEUE_DEPTH.
- Asserting rst mid-operation immediately forces all reset values, regardless of the clock.

## Structure
- Shared package holds:
  - typedef for the queue entry {index, data}
  - typedef for the FSM state
  - BTB_BankOf() and IsBankConflict() functions
  - the pointer width constant
- Sub-module: btb_defer_queue, a single-push/single-pop FIFO with count, full, empty and a synchronous clear.
- The top level contains the FSM, the grant/drain logic, the output registers and the counters.

## Test plan
- Init sweep: release rst with ENTRY_NUM=16 -> we[0]=1 with wa=0..15 in cycles 1..16; initBusy falls at cycle 16; reqValid during the sweep produces no write and no drop.
- No conflict: reqAddr {4,5}, BANK_NUM=2 -> next cycle we={1,1}, wa={4,5}, queueCount stays 0.
- Conflict and drain:
  - Stimulus: cycle t, reqAddr {4,6} in RUN.
  - t+1: we={1,0}, wa[0]=4, queueCount=1.
  - With idle inputs at t+1, at t+2: we[0]=1, wa[0]=6, queueCount=0.
- Blocked drain: queue head index 2 while the new request index 8 takes port 0 -> head stays queued; port 1 carries nothing that cycle.
- Overflow: fill to 8 while drain is blocked, then one more conflicting pair -> dropPulse=1, dropCount=1, queueCount=8.
- Flush: queueCount=3, then a flush pulse -> queueCount=0, initBusy=1, wa[0]=0 on the next cycle; the sweep completes after ENTRY_NUM writes.
